// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA test-pattern generator:
//   - pattern mode encodings as driven on i_Mode
//   - the eight primary colours as 1-bit-per-channel {r,g,b} values; the
//     generator expands each bit to a full-width channel (0 or all ones)
//   - default 640x480@60 timing constants
//   - colour-bar lookup (bar index -> colour)
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [3:0] {
    MODE_BLACK = 4'd0,
    MODE_RED   = 4'd1,
    MODE_GREEN = 4'd2,
    MODE_BLUE  = 4'd3,
    MODE_WHITE = 4'd4,
    MODE_BARS  = 4'd5,
    MODE_CHECK = 4'd6,
    MODE_BOX   = 4'd7
  } mode_e;

  // {red, green, blue}, one bit each
  typedef logic [2:0] rgb1_t;

  localparam rgb1_t RGB_BLACK   = 3'b000;
  localparam rgb1_t RGB_BLUE    = 3'b001;
  localparam rgb1_t RGB_GREEN   = 3'b010;
  localparam rgb1_t RGB_CYAN    = 3'b011;
  localparam rgb1_t RGB_RED     = 3'b100;
  localparam rgb1_t RGB_MAGENTA = 3'b101;
  localparam rgb1_t RGB_YELLOW  = 3'b110;
  localparam rgb1_t RGB_WHITE   = 3'b111;

  localparam int DEF_COLOR_W    = 8;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_CHECK_LOG2 = 5;
  localparam int DEF_BOX_SIZE   = 32;

  // Standard SMPTE-like bar order, left to right
  function automatic rgb1_t bar_color(input logic [2:0] idx);
    rgb1_t c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Free-running horizontal/vertical raster counters with registered sync,
// active and position outputs.
//
// Ports:
//   CLK            pixel clock
//   i_Rst_N        asynchronous active-low reset
//   o_H_Cnt        raw column counter (pixel being generated this cycle)
//   o_V_Cnt        raw row counter
//   o_Pix_En       high once the raster is running; gates every output register
//   o_Frame_End    high while the counters sit on the last pixel of the frame
//   o_Active_Next  visible-region decode of the raw counters
//   o_H_Sync       registered active-low horizontal sync
//   o_V_Sync       registered active-low vertical sync
//   o_Active       registered visible-region flag
//   o_Col, o_Row   registered position of the output pixel
//   o_Frame_Start  registered pulse with output pixel (0,0)
// -----------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             CLK,
  input  logic             i_Rst_N,
  output logic [CNT_W-1:0] o_H_Cnt,
  output logic [CNT_W-1:0] o_V_Cnt,
  output logic             o_Pix_En,
  output logic             o_Frame_End,
  output logic             o_Active_Next,
  output logic             o_H_Sync,
  output logic             o_V_Sync,
  output logic             o_Active,
  output logic [CNT_W-1:0] o_Col,
  output logic [CNT_W-1:0] o_Row,
  output logic             o_Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             run;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  assign h_last        = (h_cnt == H_LAST);
  assign v_last        = (v_cnt == V_LAST);
  assign o_H_Cnt       = h_cnt;
  assign o_V_Cnt       = v_cnt;
  assign o_Pix_En      = run;
  assign o_Frame_End   = run & h_last & v_last;
  assign o_Active_Next = (h_cnt < H_ACT) && (v_cnt < V_ACT);

  // The raster is held for one cycle after reset release ('run' low), so the
  // first registered pixel (0,0) lands on the second clock edge. Every output
  // register updates on the same enable, keeping sync/active/position aligned
  // with the RGB registers in the parent.
  always_ff @(posedge CLK or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      run           <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_H_Sync      <= 1'b1;
      o_V_Sync      <= 1'b1;
      o_Active      <= 1'b0;
      o_Col         <= '0;
      o_Row         <= '0;
      o_Frame_Start <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + ONE;
        end else begin
          h_cnt <= h_cnt + ONE;
        end
        o_H_Sync      <= ~((h_cnt >= HS_START) && (h_cnt < HS_END));
        o_V_Sync      <= ~((v_cnt >= VS_START) && (v_cnt < VS_END));
        o_Active      <= o_Active_Next;
        o_Col         <= h_cnt;
        o_Row         <= v_cnt;
        o_Frame_Start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
// Self-timed VGA test-pattern source: solids, colour bars, checkerboard and a
// bouncing box. Mode requests are buffered and switched in only at the frame
// boundary so a frame is never drawn in two patterns.
//
// Ports:
//   CLK            pixel clock
//   i_Rst_N        asynchronous active-low reset
//   i_Mode         requested pattern (see vga_pkg::mode_e; 8-15 draw black)
//   i_Mode_Valid   one-cycle strobe capturing i_Mode into the pending register
//   o_H_Sync       active-low horizontal sync
//   o_V_Sync       active-low vertical sync
//   o_Active       high in the visible region
//   o_Col, o_Row   position of the current output pixel
//   o_Frame_Start  one-cycle pulse with output pixel (0,0)
//   o_Red/Green/Blue  colour channels, zero outside the visible region
// -----------------------------------------------------------------------------
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CHECK_LOG2 = DEF_CHECK_LOG2,
  parameter int BOX_SIZE   = DEF_BOX_SIZE
) (
  input  logic               CLK,
  input  logic               i_Rst_N,
  input  logic [3:0]         i_Mode,
  input  logic               i_Mode_Valid,
  output logic               o_H_Sync,
  output logic               o_V_Sync,
  output logic               o_Active,
  output logic [CNT_W-1:0]   o_Col,
  output logic [CNT_W-1:0]   o_Row,
  output logic               o_Frame_Start,
  output logic [COLOR_W-1:0] o_Red,
  output logic [COLOR_W-1:0] o_Green,
  output logic [COLOR_W-1:0] o_Blue
);

  localparam int CW1 = CNT_W + 1;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] BOX_X_MAX = CNT_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [CNT_W-1:0] BOX_Y_MAX = CNT_W'(V_ACTIVE - BOX_SIZE);
  localparam logic [CNT_W:0]   BOX_SPAN  = CW1'(BOX_SIZE);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             pix_en;
  logic             frame_end;
  logic             active_next;

  logic [3:0]       mode_pend;
  logic [3:0]       mode_cur;

  logic [CNT_W-1:0] box_x;
  logic [CNT_W-1:0] box_y;
  logic             box_dx_neg;
  logic             box_dy_neg;

  logic [2:0]       bar_idx;
  logic             in_box;
  rgb1_t            rgb_sel;

  vga_timing #(
    .CNT_W    (CNT_W),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .CLK           (CLK),
    .i_Rst_N       (i_Rst_N),
    .o_H_Cnt       (h_cnt),
    .o_V_Cnt       (v_cnt),
    .o_Pix_En      (pix_en),
    .o_Frame_End   (frame_end),
    .o_Active_Next (active_next),
    .o_H_Sync      (o_H_Sync),
    .o_V_Sync      (o_V_Sync),
    .o_Active      (o_Active),
    .o_Col         (o_Col),
    .o_Row         (o_Row),
    .o_Frame_Start (o_Frame_Start)
  );

  // First column of bar k: smallest col with col*8/H_ACTIVE >= k
  function automatic logic [CNT_W-1:0] bar_edge(input int k);
    return CNT_W'((k * H_ACTIVE + 7) / 8);
  endfunction

  // A strobe on the frame-end cycle still lands in pending; the current mode
  // takes the old pending value, so that strobe waits for the next frame end.
  always_ff @(posedge CLK or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      mode_pend <= '0;
      mode_cur  <= '0;
    end else begin
      if (i_Mode_Valid) mode_pend <= i_Mode;
      if (frame_end)    mode_cur  <= mode_pend;
    end
  end

  // Box steps once per frame regardless of mode. At a wall the direction flips
  // and the position holds for that update, giving one repeated frame.
  always_ff @(posedge CLK or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      box_x      <= '0;
      box_y      <= '0;
      box_dx_neg <= 1'b0;
      box_dy_neg <= 1'b0;
    end else if (frame_end) begin
      if (!box_dx_neg) begin
        if (box_x == BOX_X_MAX) box_dx_neg <= 1'b1;
        else                    box_x      <= box_x + ONE;
      end else begin
        if (box_x == '0) box_dx_neg <= 1'b0;
        else             box_x      <= box_x - ONE;
      end
      if (!box_dy_neg) begin
        if (box_y == BOX_Y_MAX) box_dy_neg <= 1'b1;
        else                    box_y      <= box_y + ONE;
      end else begin
        if (box_y == '0) box_dy_neg <= 1'b0;
        else             box_y      <= box_y - ONE;
      end
    end
  end

  // Pattern colour for the raw counter position; blanking forces black.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= bar_edge(k)) bar_idx = 3'(k);
    end

    in_box = (h_cnt >= box_x) && ({1'b0, h_cnt} < ({1'b0, box_x} + BOX_SPAN)) &&
             (v_cnt >= box_y) && ({1'b0, v_cnt} < ({1'b0, box_y} + BOX_SPAN));

    case (mode_cur)
      MODE_BLACK: rgb_sel = RGB_BLACK;
      MODE_RED:   rgb_sel = RGB_RED;
      MODE_GREEN: rgb_sel = RGB_GREEN;
      MODE_BLUE:  rgb_sel = RGB_BLUE;
      MODE_WHITE: rgb_sel = RGB_WHITE;
      MODE_BARS:  rgb_sel = bar_color(bar_idx);
      MODE_CHECK: rgb_sel = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? RGB_WHITE : RGB_BLACK;
      MODE_BOX:   rgb_sel = in_box ? RGB_WHITE : RGB_BLUE;
      default:    rgb_sel = RGB_BLACK;
    endcase

    if (!active_next) rgb_sel = RGB_BLACK;
  end

  // Colour registers share the timing block's enable so RGB stays aligned
  // with sync/active/col/row.
  always_ff @(posedge CLK or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      o_Red   <= '0;
      o_Green <= '0;
      o_Blue  <= '0;
    end else if (pix_en) begin
      o_Red   <= {COLOR_W{rgb_sel[2]}};
      o_Green <= {COLOR_W{rgb_sel[1]}};
      o_Blue  <= {COLOR_W{rgb_sel[0]}};
    end
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Self-timed VGA test-pattern source. Contains its own horizontal/vertical timing counters and drives sync, active and RGB outputs.
- Selects one of several patterns: solids, colour bars, checkerboard and a bouncing box.
- Pattern changes are applied only at frame boundaries, so no tearing.
- Sits between the keyboard/UART decode logic (mode source) and the board DAC/HDMI encoder.

Parameters:
- COLOR_W, 8, bits per colour channel; full intensity = all ones
- CNT_W, 10, width of column/row counters; requires 2^CNT_W > H_TOTAL and 2^CNT_W > V_TOTAL
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync lines
- V_BP, 33, vertical back porch
- CHECK_LOG2, 5, checker square side = 2^CHECK_LOG2 pixels
- BOX_SIZE, 32, bouncing-box side in pixels

Ports:
- CLK  in  1  pixel clock
- i_Rst_N  in  1  asynchronous active-low reset
- i_Mode  in  4  requested pattern
- i_Mode_Valid  in  1  one-cycle strobe; capture i_Mode
- o_H_Sync  out  1  active-low horizontal sync
- o_V_Sync  out  1  active-low vertical sync
- o_Active  out  1  high in visible region
- o_Col  out  CNT_W  column of current output pixel
- o_Row  out  CNT_W  row of current output pixel
- o_Frame_Start  out  1  one-cycle pulse with pixel (0,0)
- o_Red  out  COLOR_W  red
- o_Green  out  COLOR_W  green
- o_Blue  out  COLOR_W  blue

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Column counter: 0..H_TOTAL-1, wraps to 0. Row counter increments on column wrap; wraps 0..V_TOTAL-1.
- Sync windows:
  - H sync low for col in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - V sync low for row in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Active = col<H_ACTIVE and row<V_ACTIVE.
- Latency: every output is registered exactly 1 cycle after its counter value. Sync, active, col/row and RGB stay mutually aligned.
- RGB is forced to 0 whenever active is 0.
- Reset (async assert, any time mid-frame):
  - counters 0; pending and current mode 0
  - box at x=0, y=0, dx=+1, dy=+1
  - o_H_Sync=1, o_V_Sync=1, o_Active=0, o_Col=0, o_Row=0, o_Frame_Start=0, RGB=0
- After reset release, the first pixel (0,0) appears at the output on the 2nd rising edge.
- Mode handling:
  - i_Mode_Valid loads a pending register; a later strobe overwrites an earlier one.
  - Current mode <= pending when counters are at (H_TOTAL-1, V_TOTAL-1); the new mode takes effect from pixel (0,0).
  - A strobe in that same cycle is captured into pending but does not take effect until the next frame end.
- Modes (F = all ones):
  - 0: black
  - 1: red F
  - 2: green F
  - 3: blue F
  - 4: white
  - 5: colour bars. Bar index = col*8/H_ACTIVE, computed by comparing against constant bar edges (no divider). Bars in order: white, yellow, cyan, green, magenta, red, blue, black.
  - 6: checkerboard. White where col[CHECK_LOG2] XOR row[CHECK_LOG2] is 1, else black.
  - 7: bouncing box. White where x<=col<x+BOX_SIZE and y<=row<y+BOX_SIZE; blue background.
  - 8–15: black.
- Box motion:
  - Updated once per frame at the frame-end point; moves 1 pixel per axis.
  - On reaching x=H_ACTIVE-BOX_SIZE with dx=+1, dx flips to -1 that update and x stays. Symmetric at x=0 with dx=-1. Same rules for y.
  - Box keeps moving even when mode≠7.
- o_Frame_Start=1 exactly when the output is pixel (0,0).

Decomposition:
- Shared package vga_pkg holds:
  - mode encodings (MODE_BLACK..MODE_BOX)
  - 8-colour RGB constants expressed as 1-bit-per-channel values, expanded to COLOR_W in the block
  - default 640x480@60 timing constants
- One sub-module: vga_timing. It owns the counters, sync/active decode and the frame-end strobe.
- Pattern logic and box state stay in vga_pattern_gen.

Test Plan:
- Reset release, mode 0 -> o_H_Sync low for exactly 96 cycles per 800-cycle line. o_V_Sync low for exactly 2×800 cycles per 420000-cycle frame. RGB=0 throughout.
- Strobe i_Mode=1 mid-frame at row 100 -> RGB stays 0 until o_Frame_Start. Then red=255, green=0, blue=0 for all 640×480 active pixels and 0 in blanking.
- Mode 5 -> red/green/blue at cols 0, 80, 160, 240, 320, 400, 480, 560 read (255,255,255), (255,255,0), (0,255,255), (0,255,0), (255,0,255), (255,0,0), (0,0,255), (0,0,0).
- Mode 6 -> pixel (31,0) white=0, (32,0) white=255, (32,32)=0, (0,32)=255.
- Mode 7 over 610 frames -> frame n box x=n for n≤608. Frame 609 x=608 (dx flipped), frame 610 x=607. Pixel (x,y) white, pixel (x+32,y) blue.
- Assert i_Rst_N low mid-line (col 300, row 200) with mode 4 -> all outputs reach reset values immediately, with no clock edge needed. After release, mode is 0 and the first o_Frame_Start occurs 2 edges later.
